// File: rtl/mcycle_sequencer_pkg.sv
// mcycle_sequencer_pkg
//   Shared constants and types for the multi-cycle sequencer: word size,
//   opcode/funct encodings of the 16-bit ISA, state and pc_src encodings,
//   and the instruction class flag bundle produced by inst_class_decode.
package mcycle_sequencer_pkg;

    localparam int WORD_SIZE = 16;

    // Opcodes, inst[15:12]
    localparam logic [3:0] OP_BNE = 4'd0;
    localparam logic [3:0] OP_BEQ = 4'd1;
    localparam logic [3:0] OP_BGZ = 4'd2;
    localparam logic [3:0] OP_BLZ = 4'd3;
    localparam logic [3:0] OP_ADI = 4'd4;
    localparam logic [3:0] OP_ORI = 4'd5;
    localparam logic [3:0] OP_LHI = 4'd6;
    localparam logic [3:0] OP_LWD = 4'd7;
    localparam logic [3:0] OP_SWD = 4'd8;
    localparam logic [3:0] OP_JMP = 4'd9;
    localparam logic [3:0] OP_JAL = 4'd10;
    localparam logic [3:0] OP_R   = 4'd15;

    // R-type functs, inst[5:0]; 0..7 are the ALU operations
    localparam logic [5:0] FN_ALU_LAST = 6'd7;
    localparam logic [5:0] FN_JPR      = 6'd25;
    localparam logic [5:0] FN_JRL      = 6'd26;
    localparam logic [5:0] FN_WWD      = 6'd28;
    localparam logic [5:0] FN_HLT      = 6'd29;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_NEXT   = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JUMP   = 2'd2,
        PC_REG    = 2'd3
    } pc_src_t;

    // Exactly one flag is set for any inst value
    typedef struct packed {
        logic alu;
        logic load;
        logic store;
        logic branch;
        logic jmp;
        logic jal;
        logic jpr;
        logic jrl;
        logic wwd;
        logic hlt;
        logic nop;
    } inst_class_t;

endpackage

// File: rtl/mcycle_sequencer_inst_class_decode.sv
// inst_class_decode
//   Purely combinational classifier of the current IR contents.
//   Ports:
//     inst : current instruction word (opcode [15:12], funct [5:0])
//     cls  : one-hot class flags consumed by the sequencer next-state logic
//   Undefined opcodes and undefined R-type functs classify as nop.
module inst_class_decode
    import mcycle_sequencer_pkg::*;
(
    input  logic [WORD_SIZE-1:0] inst,
    output inst_class_t          cls
);

    logic [3:0] op;
    logic [5:0] funct;
    logic       unused_fields;

    assign op    = inst[15:12];
    assign funct = inst[5:0];
    // Register/immediate fields play no part in classification
    assign unused_fields = ^inst[11:6];

    always_comb begin
        cls = '0;
        case (op)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.branch = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         cls.alu    = 1'b1;
            OP_LWD:                         cls.load   = 1'b1;
            OP_SWD:                         cls.store  = 1'b1;
            OP_JMP:                         cls.jmp    = 1'b1;
            OP_JAL:                         cls.jal    = 1'b1;
            OP_R: begin
                if (funct <= FN_ALU_LAST) begin
                    cls.alu = 1'b1;
                end else begin
                    case (funct)
                        FN_JPR:  cls.jpr = 1'b1;
                        FN_JRL:  cls.jrl = 1'b1;
                        FN_WWD:  cls.wwd = 1'b1;
                        FN_HLT:  cls.hlt = 1'b1;
                        default: cls.nop = 1'b1;
                    endcase
                end
            end
            default: cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer
//   Multi-cycle IF/ID/EX/MEM/WB sequencer for the 16-bit CPU with a
//   single-port memory handshake and a retired-instruction counter.
//   Ports:
//     clk, reset_n        : rising-edge clock, async active-low reset
//     inst                : current IR contents
//     bcond               : ALU branch condition (consumed by the datapath)
//     mem_ack             : memory completed the request this cycle
//     mem_req/i_or_d/mem_we : memory request, address select, store qualifier
//     ir_write, pc_write, pc_write_cond, pc_src : IR/PC update strobes
//     reg_write, out_port_en : register file write and WWD output strobes
//     is_halted           : sticky halt flag
//     num_inst            : retired instruction count (wraps)
//     state               : current state for debug
module mcycle_sequencer
    import mcycle_sequencer_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] inst,
    input  logic                 bcond,
    input  logic                 mem_ack,
    output logic                 mem_req,
    output logic                 i_or_d,
    output logic                 mem_we,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [1:0]           pc_src,
    output logic                 reg_write,
    output logic                 out_port_en,
    output logic                 is_halted,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [2:0]           state
);

    state_t      cur;
    inst_class_t cls;
    pc_src_t     src;
    logic        unused_in;

    // bcond is applied by the datapath through pc_write_cond; nop needs no
    // explicit branch because it shares the fall-through EX -> IF path.
    assign unused_in = bcond ^ cls.nop;

    inst_class_decode u_decode (
        .inst (inst),
        .cls  (cls)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur       <= S_IF;
            num_inst  <= '0;
            is_halted <= 1'b0;
        end else begin
            case (cur)
                S_IF: begin
                    if (mem_ack) cur <= S_ID;
                end
                S_ID: begin
                    if (cls.hlt) begin
                        cur       <= S_HALT;
                        is_halted <= 1'b1;
                        num_inst  <= num_inst + WORD_SIZE'(1);
                    end else if (cls.jmp) begin
                        cur      <= S_IF;
                        num_inst <= num_inst + WORD_SIZE'(1);
                    end else if (cls.jal) begin
                        cur <= S_WB;
                    end else begin
                        cur <= S_EX;
                    end
                end
                S_EX: begin
                    if (cls.load || cls.store) begin
                        cur <= S_MEM;
                    end else if (cls.alu || cls.jrl) begin
                        cur <= S_WB;
                    end else begin
                        // branch, jpr, wwd and nop all retire here
                        cur      <= S_IF;
                        num_inst <= num_inst + WORD_SIZE'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (cls.load) begin
                            cur <= S_WB;
                        end else begin
                            cur      <= S_IF;
                            num_inst <= num_inst + WORD_SIZE'(1);
                        end
                    end
                end
                S_WB: begin
                    cur      <= S_IF;
                    num_inst <= num_inst + WORD_SIZE'(1);
                end
                S_HALT: cur <= S_HALT;
                default: cur <= S_IF;
            endcase
        end
    end

    // Strobes are gated by reset_n so they drop the moment reset asserts,
    // not at the next edge.
    always_comb begin
        mem_req       = 1'b0;
        i_or_d        = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        src           = PC_NEXT;
        reg_write     = 1'b0;
        out_port_en   = 1'b0;
        if (reset_n) begin
            case (cur)
                S_IF: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ack;
                    pc_write = mem_ack;
                end
                S_ID: begin
                    if (cls.jmp || cls.jal) begin
                        pc_write = 1'b1;
                        src      = PC_JUMP;
                    end
                end
                S_EX: begin
                    if (cls.branch) begin
                        pc_write_cond = 1'b1;
                        src           = PC_BRANCH;
                    end else if (cls.jpr || cls.jrl) begin
                        pc_write = 1'b1;
                        src      = PC_REG;
                    end else if (cls.wwd) begin
                        out_port_en = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                    mem_we  = cls.store;
                end
                S_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_src = src;
    assign state  = cur;

endmodule
